// File: rtl/fft_pkg.sv
// fft_pkg -- shared definitions for the FFT sample-buffer reader.
//   DEFAULT_DATA_WIDTH : default sample width in bits
//   DEFAULT_LOG2_N     : default log2 of the frame length
//   fft_state_e        : reader FSM states
//   fft_dbg_t          : debug snapshot exported by the reader top
package fft_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_LOG2_N     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fft_state_e;

  typedef struct packed {
    fft_state_e state;
    logic [1:0] fifo_level;
    logic       fifo_full;
    logic       rd_inflight;
  } fft_dbg_t;

endpackage

// File: rtl/fft_buf_reader_if.sv
// fft_buf_reader_if -- sample-buffer read port plus output stream.
//   mem_ren/mem_addr -> buffer, mem_rdata <- buffer one cycle after mem_ren
//   out_data/out_valid/out_last -> downstream, out_ready <- downstream
// Handshake: a sample transfers on a clock edge where out_valid and out_ready
// are both high. Once out_valid is raised it stays high and out_data/out_last
// stay stable until that transfer; out_valid never depends on out_ready.
// Modports: master = reader side, slave = buffer/consumer side.
interface fft_buf_reader_if #(
  parameter int DATA_WIDTH = fft_pkg::DEFAULT_DATA_WIDTH,
  parameter int LOG2_N     = fft_pkg::DEFAULT_LOG2_N
) ();

  logic                  mem_ren;
  logic [LOG2_N-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output mem_ren, mem_addr, out_data, out_valid, out_last,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_ren, mem_addr, out_data, out_valid, out_last,
    output mem_rdata, out_ready
  );

endinterface

// File: rtl/fft_skid_fifo2.sv
// fft_skid_fifo2 -- two-entry FIFO whose head register drives dout directly.
//   clk, clr_n    : clock, asynchronous active-low clear
//   push, din     : write request and data (dropped when full and not popping)
//   pop           : read request (ignored when empty)
//   dout          : head entry (registered)
//   full, empty   : occupancy flags; level : entry count 0..2
module fft_skid_fifo2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [1:0]            level
);

  logic [DATA_WIDTH-1:0] slot0_q;
  logic [DATA_WIDTH-1:0] slot1_q;
  logic [1:0]            level_q;
  logic                  pop_ok;
  logic                  push_ok;

  assign pop_ok  = pop && (level_q != 2'd0);
  assign push_ok = push && ((level_q != 2'd2) || pop_ok);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      level_q <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (level_q == 2'd0) slot0_q <= din;
          else                 slot1_q <= din;
          level_q <= level_q + 2'd1;
        end
        2'b01: begin
          slot0_q <= slot1_q;
          level_q <= level_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind the survivor.
          if (level_q == 2'd1) begin
            slot0_q <= din;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = slot0_q;
  assign full  = (level_q == 2'd2);
  assign empty = (level_q == 2'd0);
  assign level = level_q;

endmodule

// File: rtl/fft_buf_reader.sv
// fft_buf_reader -- reads one N-sample frame from a sample buffer and streams
// it out over a valid/ready port with a last marker.
//   clk, clr_n : clock, asynchronous active-low reset
//   start      : begin a frame (taken only in IDLE)
//   bus        : fft_buf_reader_if.master (buffer read port + output stream)
//   busy, done : frame in progress / one-cycle completion pulse
//   dbg        : FSM state, FIFO level/full, read-in-flight flag
// Build option: define FFT_READER_BITREV_EN to read addresses in bit-reversed
// order; otherwise addresses follow the read counter (natural order).
module fft_buf_reader
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LOG2_N     = DEFAULT_LOG2_N
) (
  input  logic      clk,
  input  logic      clr_n,
  input  logic      start,
  fft_buf_reader_if.master bus,
  output logic      busy,
  output logic      done,
  output fft_dbg_t  dbg
);

  localparam logic [LOG2_N-1:0] LAST_IDX = '1;

  fft_state_e        state_q, state_d;
  logic [LOG2_N-1:0] rd_cnt_q;
  logic [LOG2_N-1:0] out_cnt_q;
  logic              inflight_q;
  logic              ren;
  logic              pop;
  logic              valid;
  logic              fifo_empty;
  logic              fifo_full;
  logic [1:0]        fifo_level;
  logic [2:0]        pending;
  logic [LOG2_N-1:0] addr;

  fft_skid_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk   (clk),
    .clr_n (clr_n),
    .push  (inflight_q),      // buffer data returns the cycle after mem_ren
    .pop   (pop),
    .din   (bus.mem_rdata),
    .dout  (bus.out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign valid = ~fifo_empty;
  assign pop   = valid && bus.out_ready;

  // Reads in flight plus samples that stay queued after this cycle's
  // transfer. Crediting the transfer lets a read issue every cycle while the
  // consumer keeps up, so the stream has no bubbles.
  assign pending = {2'b00, inflight_q} + {1'b0, fifo_level} - {2'b00, pop};
  assign ren     = (state_q == ST_READ) && (pending < 3'd2);

  always_comb begin
    addr = rd_cnt_q;
`ifdef FFT_READER_BITREV_EN
    for (int i = 0; i < LOG2_N; i++) addr[i] = rd_cnt_q[LOG2_N-1-i];
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_READ;
      ST_READ:  if (ren && (rd_cnt_q == LAST_IDX)) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && (out_cnt_q == LAST_IDX)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= ren;
      if (ren) rd_cnt_q  <= rd_cnt_q + LOG2_N'(1);
      if (pop) out_cnt_q <= out_cnt_q + LOG2_N'(1);
    end
  end

  assign bus.mem_ren   = ren;
  assign bus.mem_addr  = addr;
  assign bus.out_valid = valid;
  assign bus.out_last  = valid && (out_cnt_q == LAST_IDX);
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);

  assign dbg.state       = state_q;
  assign dbg.fifo_level  = fifo_level;
  assign dbg.fifo_full   = fifo_full;
  assign dbg.rd_inflight = inflight_q;

endmodule

// File: tb/tb_fft_buf_reader.sv
// tb_fft_buf_reader -- directed bench for fft_buf_reader with LOG2_N=3 and a
// buffer model holding 0x100+i at address i. Expected {last, data} pairs are
// queued when a frame is started and checked at every output transfer.
module tb_fft_buf_reader;
  import fft_pkg::*;

  localparam int DW = 32;
  localparam int LN = 3;
  localparam int N  = 8;
  localparam int EW = DW + 1;

  logic     clk = 1'b0;
  logic     clr_n = 1'b0;
  logic     start = 1'b0;
  logic     busy;
  logic     done;
  fft_dbg_t dbg;

  fft_buf_reader_if #(.DATA_WIDTH(DW), .LOG2_N(LN)) bus ();

  fft_buf_reader #(.DATA_WIDTH(DW), .LOG2_N(LN)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .dbg   (dbg)
  );

  // ---------------- clock / buffer model ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data is only meaningful the cycle after mem_ren; other cycles carry junk.
  always @(posedge clk) begin
    if (bus.mem_ren) bus.mem_rdata <= 32'h100 + 32'(bus.mem_addr);
    else             bus.mem_rdata <= 32'hDEAD_BEEF;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];
  int xfer_cnt = 0;
  int last_xfer_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LN-1:0] exp_addr(input int i);
    logic [LN-1:0] a;
    a = LN'(i);
`ifdef FFT_READER_BITREV_EN
    return {a[0], a[1], a[2]};
`else
    return a;
`endif
  endfunction

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (clr_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_xfer: observed=0x%0h expected=none", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        check("xfer_data", 64'(bus.out_data), 64'(e[DW-1:0]));
        check("xfer_last", 64'(bus.out_last), 64'(e[DW]));
      end
      xfer_cnt++;
      last_xfer_cyc = cyc + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(output int s);
    for (int i = 0; i < N; i++)
      exp_q.push_back({(i == N - 1), 32'h100 + 32'(exp_addr(i))});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (done) begin
        d = cyc;
        break;
      end
    end
    check("done_seen", 64'(done), 64'd1);
  endtask

  task automatic wait_xfers(input int target);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (xfer_cnt >= target) break;
    end
    check("xfers_reached", 64'(xfer_cnt >= target), 64'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_ren"},   64'(bus.mem_ren),   64'd0);
    check({tag, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_data"},  64'(bus.out_data),  64'd0);
    check({tag, "_out_last"},  64'(bus.out_last),  64'd0);
    check({tag, "_busy"},      64'(busy),          64'd0);
    check({tag, "_done"},      64'(done),          64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s, d, base, maxlvl;
    logic [EW-1:0] e;
    bus.out_ready = 1'b0;

    // Reset state
    clr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("rst");
    check("rst_state", 64'(dbg.state), 64'(ST_IDLE));
    clr_n = 1'b1;
    @(posedge clk); #1;

    // A: full-rate frame, latency and done timing
    bus.out_ready = 1'b1;
    base = xfer_cnt;
    pulse_start(s);
    check("a_busy", 64'(busy), 64'd1);
    check("a_ren0", 64'(bus.mem_ren), 64'd1);
    check("a_addr0", 64'(bus.mem_addr), 64'(exp_addr(0)));
    check("a_valid_s0", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("a_addr1", 64'(bus.mem_addr), 64'(exp_addr(1)));
    check("a_valid_s1", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("a_valid_s2", 64'(bus.out_valid), 64'd1);
    wait_done(d);
    check("a_done_cyc", 64'(d - s), 64'd10);
    check("a_last_cyc", 64'(last_xfer_cyc - s), 64'd10);
    check("a_count", 64'(xfer_cnt - base), 64'd8);
    @(posedge clk); #1;
    check("a_done_pulse", 64'(done), 64'd0);
    check("a_idle", 64'(dbg.state), 64'(ST_IDLE));
    check("a_q_empty", 64'(exp_q.size()), 64'd0);

    // B: backpressure for 5 cycles after the 3rd transfer
    base = xfer_cnt;
    pulse_start(s);
    wait_xfers(base + 3);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      e = exp_q[0];
      check("b_hold_valid", 64'(bus.out_valid), 64'd1);
      check("b_hold_data", 64'(bus.out_data), 64'(e[DW-1:0]));
      check("b_hold_last", 64'(bus.out_last), 64'(e[DW]));
      check("b_ren_off", 64'(bus.mem_ren), 64'd0);
      if (k >= 1) check("b_level2", 64'(dbg.fifo_level), 64'd2);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done(d);
    check("b_count", 64'(xfer_cnt - base), 64'd8);
    check("b_q_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;

    // C: random out_ready
    base = xfer_cnt;
    maxlvl = 0;
    bus.out_ready = 1'($urandom_range(0, 1));
    pulse_start(s);
    for (int k = 0; k < 400; k++) begin
      if (int'(dbg.fifo_level) > maxlvl) maxlvl = int'(dbg.fifo_level);
      if (done) break;
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    check("c_done_seen", 64'(done), 64'd1);
    check("c_count", 64'(xfer_cnt - base), 64'd8);
    check("c_max_level_le2", 64'(maxlvl <= 2), 64'd1);
    check("c_q_empty", 64'(exp_q.size()), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    // D: start re-pulsed during READ is ignored
    base = xfer_cnt;
    pulse_start(s);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("d_state_read", 64'(dbg.state), 64'(ST_READ));
    wait_done(d);
    check("d_count", 64'(xfer_cnt - base), 64'd8);
    repeat (6) @(posedge clk);
    #1;
    check("d_no_restart_busy", 64'(busy), 64'd0);
    check("d_no_restart_count", 64'(xfer_cnt - base), 64'd8);

    // E: reset mid-frame, then a clean frame
    base = xfer_cnt;
    pulse_start(s);
    wait_xfers(base + 4);
    clr_n = 1'b0;
    #1;
    check_outputs_zero("e_rst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
    base = xfer_cnt;
    repeat (4) @(posedge clk);
    #1;
    check("e_idle_valid", 64'(bus.out_valid), 64'd0);
    check("e_idle_busy", 64'(busy), 64'd0);
    check("e_no_stale", 64'(xfer_cnt - base), 64'd0);
    pulse_start(s);
    wait_done(d);
    check("e_count", 64'(xfer_cnt - base), 64'd8);
    check("e_q_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
